// File: rtl/button_arbiter.sv
// button_arbiter: per-button press detection feeding a round-robin
// command arbiter with a valid/ready handshake.
// Optional feature macro: BUTTON_ARBITER_AUTO_REPEAT_EN
// (when defined, a held button re-issues a press every REPEAT_CYC cycles).
module button_arbiter #(
  parameter int NUM_BTN    = 4,
  parameter int ID_W       = 2,
  parameter int REPEAT_CYC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] level,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [ID_W-1:0]    cmd_id,
  output logic [NUM_BTN-1:0] pending,
  output logic [7:0]         overrun_cnt
);

  typedef enum logic [1:0] {P_IDLE, P_PULSE, P_HELD} press_st_e;
  typedef enum logic       {C_IDLE, C_OFFER}         ctrl_st_e;

  // Reject illegal parameterisations at elaboration time.
  if (NUM_BTN < 2 || NUM_BTN > 8) begin : g_bad_num_btn
    $error("NUM_BTN must be in 2..8");
  end
  if ((1 << ID_W) < NUM_BTN) begin : g_bad_id_w
    $error("ID_W too narrow for NUM_BTN");
  end
  if (REPEAT_CYC < 2 || REPEAT_CYC > 255) begin : g_bad_repeat
    $error("REPEAT_CYC must be in 2..255");
  end

  press_st_e            r_press_st [NUM_BTN];
  press_st_e            w_press_nxt [NUM_BTN];
  logic [NUM_BTN-1:0]   w_event;
  logic [NUM_BTN-1:0]   w_clr;
  logic [NUM_BTN-1:0]   r_pending;
  logic [NUM_BTN-1:0]   w_pend_nxt;
  logic [7:0]           r_overrun;
  logic [7:0]           w_ovr_nxt;
  logic [3:0]           w_lost;
  logic [8:0]           w_ovr_sum;
  ctrl_st_e             r_ctrl_st;
  ctrl_st_e             w_ctrl_nxt;
  logic                 w_accept;
  logic [ID_W-1:0]      r_cmd_id;
  logic [ID_W-1:0]      r_last_grant;
  logic [ID_W-1:0]      w_winner;

  // First pending index after the last grant, wrapping modulo NUM_BTN.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_BTN-1:0] pend,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_BTN; off++) begin
      idx = int'(last) + off;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      if (!found && pend[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Press FSM next state: any low level returns to IDLE.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      w_press_nxt[i] = P_IDLE;
      if (level[i]) begin
        w_press_nxt[i] = (r_press_st[i] == P_IDLE) ? P_PULSE : P_HELD;
      end
    end
  end

  // Press FSM state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these arrays are plain flops holding control state, so they are reset like any register.
      for (int i = 0; i < NUM_BTN; i++) r_press_st[i] <= P_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      for (int i = 0; i < NUM_BTN; i++) r_press_st[i] <= w_press_nxt[i];
    end
  end

`ifdef BUTTON_ARBITER_AUTO_REPEAT_EN
  logic [7:0]         r_rep_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] w_rep_hit;

  // Repeat strobe fires on the last cycle of each REPEAT_CYC window in HELD.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      w_rep_hit[i] = (r_press_st[i] == P_HELD) && level[i] &&
                     (r_rep_cnt[i] == 8'(REPEAT_CYC - 1));
      w_event[i]   = (r_press_st[i] == P_PULSE) || w_rep_hit[i];
    end
  end

  // Repeat counters run from HELD entry and clear whenever HELD is left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BTN; i++) r_rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_press_nxt[i] != P_HELD || w_rep_hit[i]) r_rep_cnt[i] <= '0;
        else if (r_press_st[i] == P_HELD)             r_rep_cnt[i] <= r_rep_cnt[i] + 8'd1;
      end
    end
  end
`else
  // Without auto-repeat only the single PULSE cycle produces an event.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) w_event[i] = (r_press_st[i] == P_PULSE);
  end
`endif

  // Controller next state: offer while anything is pending, leave on accept.
  always_comb begin
    w_ctrl_nxt = r_ctrl_st;
    w_accept   = 1'b0;
    case (r_ctrl_st)
      C_IDLE:  if (|r_pending) w_ctrl_nxt = C_OFFER;
      C_OFFER: if (cmd_ready) begin
        w_accept   = 1'b1;
        w_ctrl_nxt = C_IDLE;
      end
      default: w_ctrl_nxt = C_IDLE;
    endcase
  end

  assign w_winner = rr_pick(r_pending, r_last_grant);
  assign w_clr    = w_accept ? (NUM_BTN'(1) << r_cmd_id) : '0;

  // Pending update (set beats clear) and count of presses lost this cycle.
  always_comb begin
    w_pend_nxt = r_pending;
    w_lost     = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (w_event[i]) begin
        if (r_pending[i] && !w_clr[i]) w_lost = w_lost + 4'd1;
        w_pend_nxt[i] = 1'b1;
      end else if (w_clr[i]) begin
        w_pend_nxt[i] = 1'b0;
      end
    end
    w_ovr_sum = {1'b0, r_overrun} + {5'd0, w_lost};
    w_ovr_nxt = w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
  end

  // Controller, grant history, pending bits and overrun counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl_st    <= C_IDLE;
      r_cmd_id     <= '0;
      r_last_grant <= ID_W'(NUM_BTN - 1);
      r_pending    <= '0;
      r_overrun    <= '0;
    end else begin
      r_ctrl_st <= w_ctrl_nxt;
      if (r_ctrl_st == C_IDLE && |r_pending) r_cmd_id <= w_winner;
      if (w_accept) r_last_grant <= r_cmd_id;
      r_pending <= w_pend_nxt;
      r_overrun <= w_ovr_nxt;
    end
  end

  assign cmd_valid   = (r_ctrl_st == C_OFFER);
  assign cmd_id      = r_cmd_id;
  assign pending     = r_pending;
  assign overrun_cnt = r_overrun;

endmodule

// File: tb/tb_button_arbiter.sv
// Self-checking bench for button_arbiter (default build, auto-repeat off).
// Expected command ids are queued when stimulus is applied and compared
// by a monitor when the DUT completes a handshake.
module tb_button_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] level;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [3:0] pending;
  logic [7:0] overrun_cnt;

  button_arbiter #(.NUM_BTN(4), .ID_W(2), .REPEAT_CYC(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .level       (level),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_id      (cmd_id),
    .pending     (pending),
    .overrun_cnt (overrun_cnt)
  );

  typedef struct {
    logic [3:0] lvl;
    int         n;
    int         hold;
    logic [1:0] ids [4];
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q [$];
  int         cyc = 0;
  int         last_cyc = 0;
  int         n_acc = 0;
  int         vec_acc = 0;
  bit         in_vec = 1'b0;
  vec_t       tbl [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input int b);
    level[b] = 1'b1;
    step();
    step();
    level[b] = 1'b0;
    step();
    step();
  endtask

  task automatic wait_drain(input int bound);
    int c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      step();
      c++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Handshake monitor: a transfer completes at the edge following this sample.
  always @(negedge clk) begin
    if (reset && cmd_valid && cmd_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd actual id=%0d required=no command", cmd_id);
      end else begin
        check("cmd_id", cmd_id, exp_q.pop_front());
        check("pending_at_accept", pending[cmd_id], 1);
        if (in_vec && vec_acc > 0) check("accept_spacing", cyc - last_cyc, 2);
        vec_acc++;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b1011, 3, 20, '{2'd0, 2'd1, 2'd3, 2'd0}};
    tbl[1] = '{4'b0100, 1, 20, '{2'd2, 2'd0, 2'd0, 2'd0}};
    tbl[2] = '{4'b0011, 2, 6,  '{2'd0, 2'd1, 2'd0, 2'd0}};
    tbl[3] = '{4'b1111, 4, 12, '{2'd2, 2'd3, 2'd0, 2'd1}};
    tbl[4] = '{4'b0001, 1, 3,  '{2'd0, 2'd0, 2'd0, 2'd0}};
    tbl[5] = '{4'b1000, 1, 1,  '{2'd3, 2'd0, 2'd0, 2'd0}};
    tbl[6] = '{4'b0110, 2, 20, '{2'd1, 2'd2, 2'd0, 2'd0}};

    reset = 1'b1; level = '0; cmd_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_valid",   cmd_valid,   0);
    check("rst_id",      cmd_id,      0);
    check("rst_pending", pending,     0);
    check("rst_overrun", overrun_cnt, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    step();

    // Minimum latency: edge k PULSE, k+1 pending, k+2 offer.
    level = 4'b0010;
    step();
    check("lat_k_pending", pending, 4'b0000);
    step();
    check("lat_k1_pending", pending, 4'b0010);
    check("lat_k1_valid", cmd_valid, 0);
    step();
    check("lat_k2_valid", cmd_valid, 1);
    check("lat_k2_id", cmd_id, 1);

    // Offer held stable while the consumer stalls and another press arrives.
    level = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", cmd_valid, 1);
      check("stall_id", cmd_id, 1);
    end
    check("stall_pending", pending, 4'b1010);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    cmd_ready = 1'b1;
    wait_drain(20);
    level = '0;
    repeat (4) step();

    // Table vectors: simultaneous rises, round-robin order, one per 2 cycles.
    for (int v = 0; v < 7; v++) begin
      int acc0;
      acc0    = n_acc;
      vec_acc = 0;
      in_vec  = 1'b1;
      for (int k = 0; k < tbl[v].n; k++) exp_q.push_back(tbl[v].ids[k]);
      level = tbl[v].lvl;
      repeat (tbl[v].hold) step();
      level = '0;
      wait_drain(100);
      repeat (4) step();
      in_vec = 1'b0;
      check("vec_cmd_count", n_acc - acc0, tbl[v].n);
      check("vec_pending_empty", pending, 0);
      check("vec_valid_low", cmd_valid, 0);
    end

    // Overrun: three presses while stalled lose two.
    cmd_ready = 1'b0;
    repeat (3) press_btn(0);
    check("ovr_pending", pending, 4'b0001);
    check("ovr_count2", overrun_cnt, 2);
    check("ovr_offer_id", cmd_id, 0);

    // Set wins: a press ending on the accept edge keeps pending[0] set, no overrun.
    level[0] = 1'b1;
    step();
    cmd_ready = 1'b1;
    exp_q.push_back(2'd0);
    step();
    cmd_ready = 1'b0;
    level[0]  = 1'b0;
    check("setwin_pending", pending[0], 1);
    check("setwin_overrun", overrun_cnt, 2);
    check("setwin_q_empty", exp_q.size(), 0);
    step();

    // Saturation: 253 more lost presses reach 255, further ones stay there.
    repeat (253) press_btn(0);
    check("ovr_count255", overrun_cnt, 255);
    repeat (44) press_btn(0);
    check("ovr_saturated", overrun_cnt, 255);
    check("ovr_pending_still", pending, 4'b0001);
    exp_q.push_back(2'd0);
    cmd_ready = 1'b1;
    wait_drain(20);
    repeat (3) step();

    // Reset between edges during an offer; level[1] held through release.
    cmd_ready = 1'b0;
    level = 4'b0100;
    repeat (4) step();
    check("pre_rst_valid", cmd_valid, 1);
    check("pre_rst_id", cmd_id, 2);
    level = 4'b0010;
    step();
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", cmd_valid, 0);
    check("midrst_pending", pending, 0);
    check("midrst_overrun", overrun_cnt, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    exp_q.push_back(2'd1);
    cmd_ready = 1'b1;
    wait_drain(20);
    level = '0;
    repeat (4) step();
    check("final_pending", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_arbiter.md
BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 4: number of level inputs (legal 2..8).
REQ-002 The block SHALL have parameter ID_W, default 2: width of cmd_id (≥ clog2(NUM_BTN)).
REQ-003 The block SHALL have parameter REPEAT_CYC, default 8: auto-repeat period in cycles (legal 2..255); used only under AUTO_REPEAT_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port level, input, NUM_BTN bits: button levels, synchronous to clk, not synchronized internally.
REQ-007 The block SHALL have port cmd_ready, input, 1 bit: consumer accepts the offered command.
REQ-008 The block SHALL have port cmd_valid, output, 1 bit: a command is offered.
REQ-009 The block SHALL have port cmd_id, output, ID_W bits: index of the offered button.
REQ-010 The block SHALL have port pending, output, NUM_BTN bits: registered, not-yet-accepted presses.
REQ-011 The block SHALL have port overrun_cnt, output, 8 bits: count of presses lost because pending was already set.

Function
REQ-012 Each button SHALL have its own 3-state press FSM (IDLE, PULSE, HELD): IDLE→PULSE on level=1; PULSE→HELD on level=1; HELD→HELD on level=1; any state→IDLE on level=0.
REQ-013 A press SHALL be one cycle in PULSE; pending[i] SHALL be set at the clock edge that ends that PULSE cycle.
REQ-014 If pending[i] is being set and cleared in the same cycle, set SHALL win and pending[i] SHALL stay 1.
REQ-015 A press on button i while pending[i]=1 and not being cleared SHALL leave pending unchanged and increment overrun_cnt, saturating at 255.
REQ-016 The controller FSM SHALL have states IDLE and OFFER.
REQ-017 In IDLE with pending≠0, the FSM SHALL load cmd_id with the round-robin winner, assert cmd_valid and go to OFFER at the next edge.
REQ-018 In IDLE with pending=0, the FSM SHALL stay in IDLE with cmd_valid=0.
REQ-019 In OFFER, cmd_valid SHALL be 1 and cmd_id SHALL be held stable until cmd_ready=1.
REQ-020 In OFFER with cmd_ready=1, the FSM SHALL clear pending[cmd_id], set last_grant=cmd_id and return to IDLE, so the maximum throughput is one command per 2 cycles.
REQ-021 Round-robin SHALL search indices last_grant+1, last_grant+2, … modulo NUM_BTN and pick the first with pending set.
REQ-022 cmd_ready while cmd_valid=0 SHALL be ignored.
REQ-023 Minimum latency SHALL be: level rises, sampled at edge k (PULSE) → pending set at edge k+1 → cmd_valid=1 after edge k+2.

Reset
REQ-024 On reset=0, all press FSMs and the controller SHALL go to IDLE immediately without waiting for a clock edge.
REQ-025 On reset=0, pending SHALL be 0, cmd_valid SHALL be 0, cmd_id SHALL be 0 and overrun_cnt SHALL be 0.
REQ-026 On reset=0, last_grant SHALL be set to NUM_BTN-1 so that index 0 has first priority.
REQ-027 Reset asserted mid-OFFER SHALL discard the offered command with no acceptance recorded.
REQ-028 A level held high through reset release SHALL register a press: the press FSM starts in IDLE.

Configuration
REQ-029 With macro BUTTON_ARBITER_AUTO_REPEAT_EN defined, each button in HELD SHALL run a counter that re-sets pending[i] every REPEAT_CYC cycles while held, counting from HELD entry.
REQ-030 Each auto-repeat re-set SHALL follow the same rules as a press: set-wins and overrun counting.
REQ-031 Under BUTTON_ARBITER_AUTO_REPEAT_EN, the counter SHALL clear on leaving HELD.
REQ-032 Without BUTTON_ARBITER_AUTO_REPEAT_EN, no repeat counters SHALL exist and HELD SHALL generate no events.

Verification
REQ-033 Scenario: level[2] 0→1 held 20 cycles, cmd_ready=1 → exactly one command with cmd_id=2 (macro off); pending[2] clears in the accept cycle.
REQ-034 Scenario: level=4'b1011 rising in the same cycle, cmd_ready=1 → cmd_id sequence 0,1,3 on consecutive 2-cycle boundaries.
REQ-035 Scenario: cmd_id=1 offered, cmd_ready=0 for 10 cycles while button 3 is pressed → cmd_id stays 1, cmd_valid stays 1; after accept, next cmd_id=3.
REQ-036 Scenario: button 0 pressed 3 times with cmd_ready=0 → pending[0]=1, overrun_cnt=2; 300 such presses → overrun_cnt=255.
REQ-037 Scenario: reset pulsed low mid-OFFER between clock edges → cmd_valid=0 and pending=0 at once; after release, a held level[1] yields cmd_id=1.
REQ-038 Scenario: macro on, REPEAT_CYC=8, level[0] held 40 cycles, cmd_ready=1 → 1 initial command plus a repeat command every 8 cycles while held.
